// File: rtl/aes_pkg.sv
// Shared AES-128 tables, GF(2^8) helpers and FSM encoding
// for the iterative cipher core.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_fsm_e;

  // Byte 0 of the table sits in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4
  function automatic logic [127:0] shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(
    input logic [31:0] c
  );
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  endfunction

  function automatic logic [127:0] mix_columns(
    input logic [127:0] s
  );
    return {mix_col(s[127:96]), mix_col(s[95:64]),
            mix_col(s[63:32]),  mix_col(s[31:0])};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One AES encryption round: SubBytes, ShiftRows,
// MixColumns (bypassed on the final round), AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         final_i,
  output logic [127:0] state_o
);

  logic [127:0] sr;
  logic [127:0] mc;

  assign sr = shift_rows(sub_bytes(state_i));
  assign mc = final_i ? sr : mix_columns(sr);
  assign state_o = mc ^ rk_i;

endmodule

// File: rtl/aes128_encrypt_block.sv
// Iterative AES-128 encrypt core, one round per clock.
// AES_DONE_PULSE_EN adds a one-cycle done output.
module aes128_encrypt_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         encryptEnable,
  input  logic [127:0] key,
  input  logic [127:0] inputData,
  output logic [127:0] outputData
`ifdef AES_DONE_PULSE_EN
  ,
  output logic         done
`endif
);

  localparam logic [3:0] NR_W = 4'(NR);

  aes_fsm_e     fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] out_q, out_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  logic [127:0] rk_nx;
  logic [127:0] rnd_st;
  logic         last;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t, n0, n1, n2, n3;

  // Next round key from the current one
  assign w0 = rk_q[127:96];
  assign w1 = rk_q[95:64];
  assign w2 = rk_q[63:32];
  assign w3 = rk_q[31:0];
  assign t  = sub_word({w3[23:0], w3[31:24]})
            ^ {rcon(rnd_q), 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_nx = {n0, n1, n2, n3};

  assign last = (rnd_q == NR_W);

  aes_round u_round (
    .state_i (state_q),
    .rk_i    (rk_nx),
    .final_i (last),
    .state_o (rnd_st)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      out_q   <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      out_q   <= out_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (encryptEnable) fsm_d = ROUND;
      ROUND:   if (last) fsm_d = DONE;
      DONE:    if (!encryptEnable) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    out_d   = out_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (encryptEnable) begin
          state_d = inputData ^ key;
          rk_d    = key;
          rnd_d   = 4'd1;
        end
      end
      ROUND: begin
        state_d = rnd_st;
        rk_d    = rk_nx;
        rnd_d   = rnd_q + 4'd1;
        if (last) begin
          out_d  = rnd_st;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign outputData = out_q;

`ifdef AES_DONE_PULSE_EN
  assign done = done_q;
`else
  logic unused_done;
  assign unused_done = done_q;
`endif

endmodule

// File: tb/tb_aes128_encrypt_block.sv
// Self-checking bench for the AES-128 core: FIPS vectors,
// random blocks against a byte-level model, and corner runs.
module tb_aes128_encrypt_block;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         encryptEnable;
  logic [127:0] key;
  logic [127:0] inputData;
  logic [127:0] outputData;
`ifdef AES_DONE_PULSE_EN
  logic         done;
`endif

  aes128_encrypt_block dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .encryptEnable (encryptEnable),
    .key           (key),
    .inputData     (inputData),
    .outputData    (outputData)
`ifdef AES_DONE_PULSE_EN
    ,
    .done          (done)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0]   sb [256];
  logic [127:0] prev;

  typedef struct {
    string        name;
    logic [127:0] k;
    logic [127:0] p;
    logic [127:0] c;
  } vec_t;

  vec_t vecs [3];

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  // S-box from its definition: GF inverse then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
            ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] kin,
                                           input logic [127:0] pin);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] c [4];
    logic [7:0] rc, t0;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      k[i] = kin[127-8*i -: 8];
      s[i] = pin[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int rn = 1; rn <= 10; rn++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          t[row+4*col] = s[row+4*((col+row)%4)];
      for (int col = 0; col < 4; col++) begin
        for (int j = 0; j < 4; j++) c[j] = t[4*col+j];
        for (int j = 0; j < 4; j++) begin
          if (rn < 10)
            s[4*col+j] = gmul(8'h02, c[j]) ^ gmul(8'h03, c[(j+1)%4])
                       ^ c[(j+2)%4] ^ c[(j+3)%4];
          else
            s[4*col+j] = c[j];
        end
      end
      t0   = sb[k[13]] ^ rc;
      k[1] = k[1] ^ sb[k[14]];
      k[2] = k[2] ^ sb[k[15]];
      k[3] = k[3] ^ sb[k[12]];
      k[0] = k[0] ^ t0;
      for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, got, exp);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Start at edge E, drop enable after E+1, check hold and result
  task automatic do_run(input string nm, input logic [127:0] k,
                        input logic [127:0] p, input logic [127:0] exp);
    int dcnt;
    dcnt = 0;
    @(negedge clk);
    key = k;
    inputData = p;
    encryptEnable = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 1) encryptEnable = 1'b0;
`ifdef AES_DONE_PULSE_EN
      if (done) dcnt++;
`endif
      if (cyc == 9) chk({nm, " hold"}, outputData, prev);
      if (cyc == 11) chk(nm, outputData, exp);
    end
`ifdef AES_DONE_PULSE_EN
    chk({nm, " done"}, 128'(dcnt), 128'd1);
`endif
    prev = exp;
  endtask

  initial begin
    logic [127:0] k, p, e;
    vecs[0] = '{"appB", KB, PB, CB};
    vecs[1] = '{"appC1", KC, PC, CC};
    vecs[2] = '{"zero", 128'h0, 128'h0, CZ};
    build_sbox();

    n_rst = 1'b0;
    encryptEnable = 1'b0;
    key = '0;
    inputData = '0;
    prev = '0;
    repeat (3) @(negedge clk);
    chk("reset out", outputData, 128'h0);
`ifdef AES_DONE_PULSE_EN
    chk("reset done", 128'(done), 128'h0);
`endif
    n_rst = 1'b1;

    for (int i = 0; i < 3; i++)
      do_run(vecs[i].name, vecs[i].k, vecs[i].p, vecs[i].c);

    for (int i = 0; i < 6; i++) begin
      k = rnd128();
      p = rnd128();
      e = aes_ref(k, p);
      do_run($sformatf("rand%0d", i), k, p, e);
    end

    // Enable held 30 cycles: one encryption only
    @(negedge clk);
    key = '0;
    inputData = '0;
    encryptEnable = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 3) begin
        key = rnd128();
        inputData = rnd128();
      end
      if (cyc == 11) chk("hold30 result", outputData, CZ);
      if (cyc > 11) chk($sformatf("hold30 stable c%0d", cyc), outputData, CZ);
    end
    encryptEnable = 1'b0;
    repeat (2) @(negedge clk);
    prev = CZ;

    // Inputs changed mid-operation
    @(negedge clk);
    key = KB;
    inputData = PB;
    encryptEnable = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 3) begin
        key = rnd128();
        inputData = rnd128();
      end
      if (cyc == 11) chk("input change", outputData, CB);
    end
    encryptEnable = 1'b0;
    repeat (2) @(negedge clk);

    // Async reset mid-operation, then a fresh run
    @(negedge clk);
    key = KC;
    inputData = PC;
    encryptEnable = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    key = KB;
    inputData = PB;
    n_rst = 1'b0;
    #1;
    chk("async reset", outputData, 128'h0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 9) chk("post-reset hold", outputData, 128'h0);
      if (cyc == 11) chk("post-reset run", outputData, CB);
    end
    encryptEnable = 1'b0;
    repeat (2) @(negedge clk);

    // Enable dropped during rounds, then re-raised
    @(negedge clk);
    key = KC;
    inputData = PC;
    encryptEnable = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 4) encryptEnable = 1'b0;
      if (cyc == 11) chk("drop enable", outputData, CC);
    end
    encryptEnable = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 1) encryptEnable = 1'b0;
      if (cyc == 11) chk("re-raise", outputData, CC);
    end
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
